repeat_nfa_counted: RTL and testbench

- Parametrised counted-repeat NFA stage. It matches one byte class repeated MIN_REP..MAX_REP times, or unbounded, in a byte stream.
- Replaces hand-unrolled chains of per-repeat branch modules. Chains with other NFA stages through en/match, so the match output of one stage drives the en input of the next.
- Adds a stall qualifier (valid), case folding, a negated class, an unbounded mode, and a saturating hit counter.

---
 rtl/repeat_nfa_counted.sv | 128 ++++++++++++
 tb/tb_repeat_nfa_counted.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/repeat_nfa_counted.sv
// ---------------------------------------------------------------------------
// repeat_nfa_counted
//
// Counted-repeat NFA stage. It matches one byte class repeated MIN_REP..MAX_REP
// times in a byte stream. MAX_REP = 0 means the repeat is unbounded. Stages
// chain through en/match: the match of one stage drives the en of the next.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, ACTIVE-HIGH (1 = reset), despite the name
//   en         the byte consumed this valid cycle may start this sub-pattern
//   valid      payload qualifier; 0 = stall, nothing consumed, state holds
//   payload    stream byte
//   cnt_clr    synchronous clear of hit_count (wins over an increment)
//   match      sub-pattern ended on the last consumed byte (from registers)
//   active     at least one thread in progress
//   hit_count  saturating count of matches consumed by a valid byte
// ---------------------------------------------------------------------------
module repeat_nfa_counted #(
    parameter int         MIN_REP = 1,
    parameter int         MAX_REP = 4,
    parameter logic [7:0] LO_CHAR = 8'h30,
    parameter logic [7:0] HI_CHAR = 8'h39,
    parameter bit         NEGATE  = 1'b0,
    parameter bit         NOCASE  = 1'b0,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             valid,
    input  logic [7:0]       payload,
    input  logic             cnt_clr,
    output logic             match,
    output logic             active,
    output logic [CNT_W-1:0] hit_count
);

    // In unbounded mode the last stage self-loops, so MIN_REP stages suffice.
    localparam bit UNBOUNDED = (MAX_REP == 0);
    localparam int D         = UNBOUNDED ? MIN_REP : MAX_REP;

    // ------------------------------------------------------------------
    // Parameter legality, rejected at elaboration.
    // ------------------------------------------------------------------
    if (MIN_REP < 1 || MIN_REP > 64) begin : g_bad_min
        $error("repeat_nfa_counted: MIN_REP must be 1..64");
    end
    if (!UNBOUNDED && (MAX_REP < MIN_REP || MAX_REP > 64)) begin : g_bad_max
        $error("repeat_nfa_counted: MAX_REP must be 0 or MIN_REP..64");
    end
    if (HI_CHAR < LO_CHAR) begin : g_bad_rng
        $error("repeat_nfa_counted: HI_CHAR must be >= LO_CHAR");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt
        $error("repeat_nfa_counted: CNT_W must be 2..32");
    end

    // ------------------------------------------------------------------
    // Class decode.
    // ------------------------------------------------------------------
    logic [7:0] folded;
    logic       in_rng;
    logic       cls;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        folded = payload;
        if (NOCASE && payload >= 8'h41 && payload <= 8'h5A) begin
            folded = payload | 8'h20;
        end
        in_rng = (folded >= LO_CHAR) && (folded <= HI_CHAR);
        cls    = in_rng ^ NEGATE;
    end

    // ------------------------------------------------------------------
    // Thread state. st[k] = 1: k class bytes consumed since an activation.
    // chain[0] is the activation, chain[k] mirrors st[k].
    // ------------------------------------------------------------------
    logic [D:1] st;
    logic [D:1] st_nxt;
    logic [D:0] chain;

    assign chain = {st, en};

    always_comb begin
        st_nxt = st;
        if (valid) begin
            for (int k = 1; k <= D; k++) begin
                st_nxt[k] = chain[k-1] & cls;
            end
            if (UNBOUNDED) begin
                st_nxt[D] = (chain[D-1] | st[D]) & cls;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        // NOTE: the thread vector is a plain register bank, not a memory, so
        // it is reset; a stale thread after reset would raise a false match.
        if (reset_n) begin
            st <= '0;
        end else begin
            st <= st_nxt;
        end
    end

    assign match  = |st[D:MIN_REP];
    assign active = |st;

    // ------------------------------------------------------------------
    // Hit counter: counts a standing match when the next valid byte is
    // consumed, and saturates at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            hit_count <= '0;
        end else if (cnt_clr) begin
            hit_count <= '0;
        end else if (valid && match && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_repeat_nfa_counted.sv
module tb_repeat_nfa_counted;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] payload = 8'h00;
    logic       cnt_clr = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // d0: defaults, class '0'..'9', 1..4
    logic        m0, a0;
    logic [15:0] h0;
    repeat_nfa_counted d0 (.clk(clk), .reset_n(reset_n), .en(en), .valid(valid),
        .payload(payload), .cnt_clr(cnt_clr), .match(m0), .active(a0), .hit_count(h0));

    // d1: exactly 3 digits
    logic        m1, a1;
    logic [15:0] h1;
    repeat_nfa_counted #(.MIN_REP(3), .MAX_REP(3)) d1 (.clk(clk), .reset_n(reset_n),
        .en(en), .valid(valid), .payload(payload), .cnt_clr(cnt_clr),
        .match(m1), .active(a1), .hit_count(h1));

    // d2: 2 or more digits
    logic        m2, a2;
    logic [15:0] h2;
    repeat_nfa_counted #(.MIN_REP(2), .MAX_REP(0)) d2 (.clk(clk), .reset_n(reset_n),
        .en(en), .valid(valid), .payload(payload), .cnt_clr(cnt_clr),
        .match(m2), .active(a2), .hit_count(h2));

    // d3: exactly 2 letters, case folded
    logic        m3, a3;
    logic [15:0] h3;
    repeat_nfa_counted #(.MIN_REP(2), .MAX_REP(2), .LO_CHAR(8'h61), .HI_CHAR(8'h7A),
        .NOCASE(1'b1)) d3 (.clk(clk), .reset_n(reset_n), .en(en), .valid(valid),
        .payload(payload), .cnt_clr(cnt_clr), .match(m3), .active(a3), .hit_count(h3));

    // d4: exactly 2 lowercase letters, no folding
    logic        m4, a4;
    logic [15:0] h4;
    repeat_nfa_counted #(.MIN_REP(2), .MAX_REP(2), .LO_CHAR(8'h61), .HI_CHAR(8'h7A))
        d4 (.clk(clk), .reset_n(reset_n), .en(en), .valid(valid),
        .payload(payload), .cnt_clr(cnt_clr), .match(m4), .active(a4), .hit_count(h4));

    // d5: exactly 2 non-lowercase bytes
    logic        m5, a5;
    logic [15:0] h5;
    repeat_nfa_counted #(.MIN_REP(2), .MAX_REP(2), .LO_CHAR(8'h61), .HI_CHAR(8'h7A),
        .NEGATE(1'b1)) d5 (.clk(clk), .reset_n(reset_n), .en(en), .valid(valid),
        .payload(payload), .cnt_clr(cnt_clr), .match(m5), .active(a5), .hit_count(h5));

    // d6: defaults with a 2-bit counter
    logic       m6, a6;
    logic [1:0] h6;
    repeat_nfa_counted #(.CNT_W(2)) d6 (.clk(clk), .reset_n(reset_n), .en(en),
        .valid(valid), .payload(payload), .cnt_clr(cnt_clr),
        .match(m6), .active(a6), .hit_count(h6));

    // One clock edge with the given inputs; outputs are sampled 1 time unit later.
    task automatic cycle(input logic e, input logic v, input logic [7:0] p);
        en      = e;
        valid   = v;
        payload = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        cnt_clr = 1'b0;
        cycle(1'b1, 1'b1, 8'h31);
        reset_n = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (m0 !== 1'b0) begin
            miscompares++; $display("FAIL reset_match: got %b want 0", m0);
        end
        vectors++;
        if (a0 !== 1'b0) begin
            miscompares++; $display("FAIL reset_active: got %b want 0", a0);
        end
        vectors++;
        if (h0 !== 16'd0) begin
            miscompares++; $display("FAIL reset_hit: got %0d want 0", h0);
        end
    endtask

    // "1" with en, then "2345x": match after 1..4, not after 5.
    task automatic test_bounded_run();
        string s;
        logic  exp_m;
        s = "12345x";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            cycle(i == 0, 1'b1, s[i]);
            exp_m = (i <= 3);
            vectors++;
            if (m0 !== exp_m) begin
                miscompares++;
                $display("FAIL bounded_match[%0d]: got %b want %b", i, m0, exp_m);
            end
        end
        vectors++;
        if (a0 !== 1'b0) begin
            miscompares++; $display("FAIL bounded_active: got %b want 0", a0);
        end
        vectors++;
        if (h0 !== 16'd4) begin
            miscompares++; $display("FAIL bounded_hit: got %0d want 4", h0);
        end
    endtask

    // Exactly-3 stage, en every cycle, "12a345": only the '5' edge matches.
    task automatic test_overlap();
        string s;
        logic  exp_m;
        s = "12a345";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            cycle(1'b1, 1'b1, s[i]);
            exp_m = (i == 5);
            vectors++;
            if (m1 !== exp_m) begin
                miscompares++;
                $display("FAIL overlap_match[%0d]: got %b want %b", i, m1, exp_m);
            end
        end
        vectors++;
        if (a1 !== 1'b1) begin
            miscompares++; $display("FAIL overlap_active: got %b want 1", a1);
        end
    endtask

    // Stall with garbage and en high: state and counter hold.
    task automatic test_stall();
        do_reset();
        cycle(1'b1, 1'b1, 8'h31);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'h78);
            vectors++;
            if ({m0, a0} !== 2'b11) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got m=%b a=%b want m=1 a=1", i, m0, a0);
            end
            vectors++;
            if (h0 !== 16'd0) begin
                miscompares++; $display("FAIL stall_hit[%0d]: got %0d want 0", i, h0);
            end
        end
        cycle(1'b0, 1'b1, 8'h32);
        vectors++;
        if (m0 !== 1'b1) begin
            miscompares++; $display("FAIL stall_resume_match: got %b want 1", m0);
        end
        vectors++;
        if (h0 !== 16'd1) begin
            miscompares++; $display("FAIL stall_resume_hit: got %0d want 1", h0);
        end
        // Thread is now length 2; lengths 3 and 4 match, 5 falls off.
        cycle(1'b0, 1'b1, 8'h33);
        cycle(1'b0, 1'b1, 8'h34);
        vectors++;
        if (m0 !== 1'b1) begin
            miscompares++; $display("FAIL stall_len4: got %b want 1", m0);
        end
        cycle(1'b0, 1'b1, 8'h35);
        vectors++;
        if (m0 !== 1'b0) begin
            miscompares++; $display("FAIL stall_len5: got %b want 0", m0);
        end
    endtask

    // Unbounded, MIN 2: "0123456789z" matches after bytes 2..10 only.
    task automatic test_unbounded();
        string s;
        logic  exp_m;
        s = "0123456789z";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            cycle(i == 0, 1'b1, s[i]);
            exp_m = (i >= 1) && (i <= 9);
            vectors++;
            if (m2 !== exp_m) begin
                miscompares++;
                $display("FAIL unbounded_match[%0d]: got %b want %b", i, m2, exp_m);
            end
        end
        vectors++;
        if (a2 !== 1'b0) begin
            miscompares++; $display("FAIL unbounded_active: got %b want 0", a2);
        end
    endtask

    // Case folding and negation on "Ab" and "@#".
    task automatic test_class_options();
        do_reset();
        cycle(1'b1, 1'b1, 8'h41);
        vectors++;
        if (m3 !== 1'b0) begin
            miscompares++; $display("FAIL nocase_len1: got %b want 0", m3);
        end
        cycle(1'b0, 1'b1, 8'h62);
        vectors++;
        if ({m3, m4, m5} !== 3'b100) begin
            miscompares++;
            $display("FAIL class_Ab: got fold=%b plain=%b neg=%b want 1 0 0", m3, m4, m5);
        end
        do_reset();
        cycle(1'b1, 1'b1, 8'h40);
        cycle(1'b0, 1'b1, 8'h23);
        vectors++;
        if ({m3, m4, m5} !== 3'b001) begin
            miscompares++;
            $display("FAIL class_at_hash: got fold=%b plain=%b neg=%b want 0 0 1", m3, m4, m5);
        end
    endtask

    // 2-bit counter saturation, clear priority, mid-thread reset.
    task automatic test_counter();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'h30 + 8'(i));
            if (i == 3) begin
                vectors++;
                if (h6 !== 2'd3) begin
                    miscompares++; $display("FAIL sat_reach: got %0d want 3", h6);
                end
            end
        end
        vectors++;
        if (h6 !== 2'd3) begin
            miscompares++; $display("FAIL sat_hold: got %0d want 3", h6);
        end
        cnt_clr = 1'b1;
        cycle(1'b1, 1'b1, 8'h36);
        cnt_clr = 1'b0;
        vectors++;
        if (h6 !== 2'd0) begin
            miscompares++; $display("FAIL clr_priority: got %0d want 0", h6);
        end
        cycle(1'b1, 1'b1, 8'h37);
        vectors++;
        if (h6 !== 2'd1) begin
            miscompares++; $display("FAIL count_after_clr: got %0d want 1", h6);
        end
        reset_n = 1'b1;
        cycle(1'b1, 1'b1, 8'h38);
        reset_n = 1'b0;
        vectors++;
        if ({m6, a6, h6} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrun_reset: got m=%b a=%b hit=%0d want 0 0 0", m6, a6, h6);
        end
    endtask

    initial begin
        test_reset();
        test_bounded_run();
        test_overlap();
        test_stall();
        test_unbounded();
        test_class_options();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
